// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx -- parametrised serial frame transmitter.
//
// Serialises one DATA_W-bit word per accepted send request into a frame:
// start bit (0), data LSB-first, optional parity bit, then STOP_BITS stop
// bits (1). Each bit is held on txd for CLKS_PER_BIT clocks. Frames can run
// back-to-back with no idle gap when a request is accepted in the final
// stop-bit clock.
//
// Parameters:
//   DATA_W        data bits per frame, 5..16
//   CLKS_PER_BIT  clocks per bit, >= 1
//   PARITY        0 none, 1 even, 2 odd
//   STOP_BITS     1 or 2
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   send   in   request, honoured only on an edge where ready=1
//   data   in   word to send, captured on the accepting edge
//   ready  out  block can accept send this cycle
//   txd    out  registered serial line, idle high
//   done   out  one-cycle pulse after the last stop bit completes
//   s      out  state: 00 IDLE, 01 START, 10 DATA(+parity), 11 STOP
// ---------------------------------------------------------------------------
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              txd,
    output logic              done,
    output logic [1:0]        s
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_START = 2'b01;
    localparam logic [1:0] S_DATA  = 2'b10;
    localparam logic [1:0] S_STOP  = 2'b11;

    localparam int HAS_PAR = (PARITY != 0) ? 1 : 0;
    // Bit counter must be able to hold DATA_W+1 (data bits plus parity).
    localparam int BIT_W   = $clog2(DATA_W + 2);
    localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  FRAME_LAST = BIT_W'(DATA_W - 1 + HAS_PAR);
    localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);

    // Elaboration-time rejection of unsupported configurations.
    generate
        if (DATA_W < 5 || DATA_W > 16) begin : g_bad_data_w
            $error("serial_tx: DATA_W must be in 5..16");
        end
        if (CLKS_PER_BIT < 1) begin : g_bad_clks
            $error("serial_tx: CLKS_PER_BIT must be >= 1");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("serial_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("serial_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    logic [1:0]        state_reg,    state_next;
    logic              txd_reg,      txd_next;
    logic              done_reg,     done_next;
    logic [DATA_W-1:0] shift_reg,    shift_next;
    logic              parity_reg,   parity_next;
    logic [BIT_W-1:0]  bit_cnt_reg,  bit_cnt_next;
    logic [BAUD_W-1:0] baud_cnt_reg, baud_cnt_next;

    logic bit_end;
    logic last_stop;
    logic accept;
    logic data_xor;

    assign bit_end   = (baud_cnt_reg == BAUD_LAST);
    // Final clock of the final stop bit: the slot where a new frame may start.
    assign last_stop = (state_reg == S_STOP) && (bit_cnt_reg == STOP_LAST) && bit_end;
    assign ready     = (state_reg == S_IDLE) || last_stop;
    assign accept    = send && ready;
    assign data_xor  = ^data;

    always_comb begin
        state_next    = state_reg;
        txd_next      = txd_reg;
        done_next     = 1'b0;
        shift_next    = shift_reg;
        parity_next   = parity_reg;
        bit_cnt_next  = bit_cnt_reg;
        baud_cnt_next = bit_end ? '0 : baud_cnt_reg + BAUD_W'(1);

        case (state_reg)
            S_IDLE: begin
                baud_cnt_next = '0;
                txd_next      = 1'b1;
                if (accept) begin
                    state_next   = S_START;
                    txd_next     = 1'b0;
                    shift_next   = data;
                    parity_next  = (PARITY == 2) ? ~data_xor : data_xor;
                    bit_cnt_next = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next   = S_DATA;
                    txd_next     = shift_reg[0];
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_reg == FRAME_LAST) begin
                        state_next   = S_STOP;
                        txd_next     = 1'b1;
                        bit_cnt_next = '0;
                    end else if ((HAS_PAR != 0) && (bit_cnt_reg == DATA_LAST)) begin
                        // Data exhausted; parity occupies the extra DATA slot.
                        txd_next     = parity_reg;
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end else begin
                        txd_next     = shift_reg[0];
                        shift_next   = shift_reg >> 1;
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end
            end
            default: begin  // S_STOP
                if (bit_end) begin
                    if (bit_cnt_reg == STOP_LAST) begin
                        done_next    = 1'b1;
                        bit_cnt_next = '0;
                        if (accept) begin
                            // Back-to-back: start bit follows the stop bit directly.
                            state_next  = S_START;
                            txd_next    = 1'b0;
                            shift_next  = data;
                            parity_next = (PARITY == 2) ? ~data_xor : data_xor;
                        end else begin
                            state_next = S_IDLE;
                            txd_next   = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            txd_reg      <= 1'b1;
            done_reg     <= 1'b0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            bit_cnt_reg  <= '0;
            baud_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            txd_reg      <= txd_next;
            done_reg     <= done_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            bit_cnt_reg  <= bit_cnt_next;
            baud_cnt_reg <= baud_cnt_next;
        end
    end

    assign txd  = txd_reg;
    assign done = done_reg;
    assign s    = state_reg;

endmodule

// File: doc/serial_tx.md
# serial_tx

Parametrised serial transmitter; successor to the fixed 8-bit `fsm` frame generator. Serialises one `DATA_W`-bit word per `send` request into a frame (start bit, data LSB-first, optional parity, one or two stop bits), each bit held for `CLKS_PER_BIT` clocks. It adds a ready/done handshake, back-to-back frame support and a synchronous reset, and keeps the 2-bit state output `s` for bench observation.

## Interface
- `DATA_W`, default 8: data bits per frame; legal range 5..16.
- `CLKS_PER_BIT`, default 1: clocks per bit; must be ≥1.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `send`  in  1  request; honoured only on an edge where `ready`=1.
- `data`  in  DATA_W  word; captured on the accepting edge.
- `ready`  out  1  block can accept `send` this cycle.
- `txd`  out  1  serial line; idle high; registered.
- `done`  out  1  one-cycle pulse after the last stop bit completes.
- `s`  out  2  state: 00 IDLE, 01 START, 10 DATA (includes parity bit), 11 STOP.

## Operation
- Reset (`rst`=1 at an edge): `s`=IDLE, `txd`=1, `done`=0, counters cleared, shift register cleared. `ready`=1 in the cycle after reset. `send` is ignored while `rst`=1. Reset mid-frame aborts the frame immediately and returns `txd` to 1. No partial word is resumed.
- IDLE: `txd`=1. When `send`=1 and `ready`=1, `data` is loaded into the shift register, parity is computed from `data`, and the block goes to START.
- START: `txd`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: DATA_W bits go out LSB-first, each for CLKS_PER_BIT cycles, followed by the parity bit when PARITY≠0.
  - Even parity bit = XOR of data.
  - Odd parity bit = inverted XOR of data.
  - After the last bit, the block goes to STOP.
- STOP: `txd`=1 for STOP_BITS×CLKS_PER_BIT cycles. At the end, `done` pulses and the next state is either START (a new request was accepted in the final STOP cycle) or IDLE.
- `ready` is 1 in IDLE and in the final clock of the final stop bit; otherwise 0. `send` while `ready`=0 is dropped, with no queuing and no effect on the frame in progress.
- Frame length in bits: 1 + DATA_W + (PARITY≠0) + STOP_BITS. Frame length in clocks is that value × CLKS_PER_BIT.
- The bit counter is sized to hold DATA_W+1. The baud counter is sized to ceil(log2(CLKS_PER_BIT)) bits, minimum 1 bit. Both wrap to 0 at terminal count, with no overflow past terminal.
- Out-of-range parameters are rejected at elaboration through a generate-time error.

## Timing
- Accept on edge k (`send`=`ready`=1): after edge k, `s`=START and `txd`=0.
  - Data bit i is driven from edge k+(1+i)·CLKS_PER_BIT.
  - The first stop bit starts at edge k+(1+DATA_W+P)·CLKS_PER_BIT, where P = (PARITY≠0).
- `done`=1 for exactly the one cycle following the last stop-bit cycle. It coincides with IDLE, or with START on a back-to-back frame.
- Back-to-back frames have zero idle gap. The default 8N1 configuration with CLKS_PER_BIT=1 gives exactly one frame every 10 clocks.
- Latency from accept to the first `txd` falling edge is 1 clock. There is no combinational path from `send` or `data` to `txd`.

## Test plan
- Default 8N1, CLKS_PER_BIT=1, send 0xA5 → after accept, `txd` over 10 clocks = 0,1,0,1,0,0,1,0,1,1. `s` = 01, then 10 ×8, then 11. `done` pulses at clock 11 and `ready` returns to 1.
- PARITY=1, then PARITY=2, send 0xA5 → parity bit is 0 for even and 1 for odd. The frame is 11 bits, and `s` stays at 10 for 9 bits.
- CLKS_PER_BIT=4, STOP_BITS=2, send 0x3C → each bit is held exactly 4 clocks and the frame is 44 clocks. `send` pulsed at clock 20 is ignored and the frame is unchanged.
- Back-to-back in 8N1: hold `send`=1 with data 0x00, then 0xFF → two contiguous 10-bit frames with no extra idle bit and two `done` pulses 10 clocks apart.
- Reset mid-frame: assert `rst` at data bit 3 of 0x55 → on the next edge `txd`=1, `s`=00, `done`=0, `ready`=1. A subsequent send of 0x0F produces a clean frame.
- DATA_W=5, send 0x1F → 7-bit frame: 0,1,1,1,1,1,1.
